// File: rtl/instruction_fetch.sv
// RV32I instruction-fetch stage: PC register, text ROM addressing and IF/ID
// pipeline register with stall, redirect/flush and EBREAK halt handling.
module instruction_fetch #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] RESET_PC   = 32'h0000_0800,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  STALL,
   input  logic                  REDIRECT,
   input  logic [31:0]           REDIRECT_PC,
   output logic [ADDR_WIDTH-1:0] R_ADDR,
   input  logic [31:0]           ROM_DATA,
   output logic [31:0]           PC,
   output logic [31:0]           IF_ID_INSTR,
   output logic [31:0]           IF_ID_PC,
   output logic [31:0]           IF_ID_PC4,
   output logic                  IF_ID_VALID,
   output logic                  HALTED,
   output logic [31:0]           FETCH_COUNT
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        unused_low;

   assign R_ADDR     = PC[ADDR_WIDTH+1:2];
   assign target     = {REDIRECT_PC[31:2], 2'b00};
   assign pc_plus4   = PC + 32'd4;
   assign unused_low = ^REDIRECT_PC[1:0];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state       <= S_BOOT;
         PC          <= RESET_PC;
         IF_ID_INSTR <= NOP_INSTR;
         IF_ID_PC    <= 32'd0;
         IF_ID_PC4   <= 32'd4;
         IF_ID_VALID <= 1'b0;
         HALTED      <= 1'b0;
         FETCH_COUNT <= 32'd0;
      end else begin
         unique case (state)
            S_BOOT: begin
               state <= S_RUN;
            end
            S_RUN: begin
               if (REDIRECT) begin
                  PC          <= target;
                  IF_ID_INSTR <= NOP_INSTR;
                  IF_ID_VALID <= 1'b0;
               end else if (!STALL) begin
                  IF_ID_INSTR <= ROM_DATA;
                  IF_ID_PC    <= PC;
                  IF_ID_PC4   <= pc_plus4;
                  IF_ID_VALID <= 1'b1;
                  PC          <= pc_plus4;
                  FETCH_COUNT <= FETCH_COUNT + 32'd1;
                  if (ROM_DATA == EBREAK) begin
                     state  <= S_HALT;
                     HALTED <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               // A redirect means the EBREAK sat on a squashed path.
               if (REDIRECT) begin
                  PC          <= target;
                  IF_ID_INSTR <= NOP_INSTR;
                  IF_ID_VALID <= 1'b0;
                  HALTED      <= 1'b0;
                  state       <= S_RUN;
               end else if (!STALL) begin
                  IF_ID_INSTR <= NOP_INSTR;
                  IF_ID_VALID <= 1'b0;
               end
            end
            default: begin
               state <= S_BOOT;
            end
         endcase
      end
   end

endmodule
